// File: rtl/rob_commit_ctrl_if.sv
// Commit-side bundle between ROB, free list, front end and the commit controller.
// Latency: n/a (wires only).
// Backpressure: fl_ready from the free list gates every pop carried here.
// Ports: master = ROB/free-list/front-end side, slave = rob_commit_ctrl.
interface rob_commit_ctrl_if #(
  parameter int ROB_DEPTH    = 128,
  parameter int P_ADDR_WIDTH = 7,
  parameter int INSTR_COUNT  = 2
);
  localparam int ID_W = $clog2(ROB_DEPTH);

  // ROB head window
  logic [INSTR_COUNT-1:0]                   rob_valid;
  logic [INSTR_COUNT-1:0]                   rob_exec;
  logic [INSTR_COUNT-1:0][P_ADDR_WIDTH-1:0] rob_ppdst;
  logic [INSTR_COUNT-1:0]                   rob_pop;
  // ROB tail recovery
  logic                                     rob_rec_en;
  logic [ID_W-1:0]                          rob_rec_id;
  logic                                     mis_en;
  logic [ID_W-1:0]                          mis_id;
  // free list release
  logic                                     fl_ready;
  logic [INSTR_COUNT-1:0]                   fl_push;
  logic [INSTR_COUNT-1:0][P_ADDR_WIDTH-1:0] fl_data;
  // debug / front end / stats
  logic                                     halt;
  logic                                     fe_stall;
  logic [31:0]                              commit_cnt;

  modport master (
    output rob_valid, rob_exec, rob_ppdst, mis_en, mis_id, fl_ready, halt,
    input  rob_pop, rob_rec_en, rob_rec_id, fl_push, fl_data, fe_stall, commit_cnt
  );

  modport slave (
    input  rob_valid, rob_exec, rob_ppdst, mis_en, mis_id, fl_ready, halt,
    output rob_pop, rob_rec_en, rob_rec_id, fl_push, fl_data, fe_stall, commit_cnt
  );
endinterface

// File: rtl/rob_commit_ctrl.sv
// In-order ROB commit controller with mispredict recovery, flush window and debug halt.
// Latency: pops/free-list releases combinational in the same cycle; recovery strobe one cycle after mis_en.
// Backpressure: fl_ready=0, halt, FLUSH or HALTED hold every pop at zero; the ROB simply keeps its head.
// Ports: clk, rst_n (async active-low), bus (rob_commit_ctrl_if.slave: ROB head window,
//        recovery strobe/id, mispredict report, free-list release, halt, fe_stall, commit_cnt).
module rob_commit_ctrl #(
  parameter int ROB_DEPTH    = 128,
  parameter int P_ADDR_WIDTH = 7,
  parameter int INSTR_COUNT  = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  rob_commit_ctrl_if.slave   bus
);
  localparam int ID_W = $clog2(ROB_DEPTH);
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_t;

  state_t                 state;
  logic [FC_W-1:0]        flush_cnt;
  logic                   rec_en_q;
  logic [ID_W-1:0]        rec_id_q;
  logic                   fe_stall_q;
  logic [31:0]            commit_cnt_q;

  logic [INSTR_COUNT:0]   chain;
  logic [INSTR_COUNT-1:0] pop;
  logic [31:0]            pop_cnt;
  logic [ID_W:0]          rec_sum;
  logic [ID_W-1:0]        rec_id_nxt;

  // Thermometer pop: each slot commits only if it and every older slot are
  // valid and executed. rst_n is folded in so pops drop the instant reset asserts.
  always_comb begin
    chain    = '0;
    chain[0] = rst_n && (state == RUN) && !bus.halt && bus.fl_ready;
    for (int k = 0; k < INSTR_COUNT; k++) begin
      chain[k+1] = chain[k] & bus.rob_valid[k] & bus.rob_exec[k];
    end
    pop = chain[INSTR_COUNT:1];
  end

  always_comb begin
    pop_cnt = 32'd0;
    for (int k = 0; k < INSTR_COUNT; k++) begin
      pop_cnt = pop_cnt + 32'(pop[k]);
    end
  end

  // New tail is the entry after the mispredicted branch, wrapping at ROB_DEPTH
  // (explicit compare so non-power-of-two depths also wrap correctly).
  always_comb begin
    rec_sum    = {1'b0, bus.mis_id} + (ID_W+1)'(1);
    rec_id_nxt = rec_sum[ID_W-1:0];
    if (rec_sum == (ID_W+1)'(ROB_DEPTH)) begin
      rec_id_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      flush_cnt    <= '0;
      rec_en_q     <= 1'b0;
      rec_id_q     <= '0;
      fe_stall_q   <= 1'b0;
      commit_cnt_q <= 32'd0;
    end else begin
      commit_cnt_q <= commit_cnt_q + pop_cnt;
      rec_en_q     <= 1'b0;
      case (state)
        RUN: begin
          // mis_en wins over halt; halt is looked at again when FLUSH ends.
          if (bus.mis_en) begin
            state      <= FLUSH;
            flush_cnt  <= FC_W'(FLUSH_CYCLES - 1);
            rec_en_q   <= 1'b1;
            rec_id_q   <= rec_id_nxt;
            fe_stall_q <= 1'b1;
          end else if (bus.halt) begin
            state <= HALTED;
          end
        end
        FLUSH: begin
          // flush_cnt counts remaining FLUSH cycles including the strobe cycle.
          if (flush_cnt == '0) begin
            state      <= bus.halt ? HALTED : RUN;
            fe_stall_q <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - FC_W'(1);
          end
        end
        HALTED: begin
          if (!bus.halt) begin
            state <= RUN;
          end
        end
        default: begin
          state      <= RUN;
          fe_stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rob_pop    = pop;
  assign bus.fl_push    = pop;
  assign bus.fl_data    = bus.rob_ppdst;
  assign bus.rob_rec_en = rec_en_q;
  assign bus.rob_rec_id = rec_id_q;
  assign bus.fe_stall   = fe_stall_q;
  assign bus.commit_cnt = commit_cnt_q;
endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for rob_commit_ctrl: a vector table for steady-state commit
// behaviour plus hand-written sequences for recovery, halt and reset corners.
// Inputs change 1ns after the rising edge; outputs are sampled mid-cycle.
module tb_rob_commit_ctrl;
  localparam int ROB_DEPTH    = 128;
  localparam int P_ADDR_WIDTH = 7;
  localparam int INSTR_COUNT  = 2;
  localparam int FLUSH_CYCLES = 2;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  logic [31:0] exp_cnt;

  rob_commit_ctrl_if #(
    .ROB_DEPTH(ROB_DEPTH), .P_ADDR_WIDTH(P_ADDR_WIDTH), .INSTR_COUNT(INSTR_COUNT)
  ) bus ();

  rob_commit_ctrl #(
    .ROB_DEPTH(ROB_DEPTH), .P_ADDR_WIDTH(P_ADDR_WIDTH),
    .INSTR_COUNT(INSTR_COUNT), .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] valid;
    logic [1:0] exec;
    logic       fl_ready;
    logic [6:0] ppd1;
    logic [6:0] ppd0;
    logic [1:0] exp_pop;
    int         exp_delta;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] e, input logic r);
    bus.rob_valid = v;
    bus.rob_exec  = e;
    bus.fl_ready  = r;
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    exp_cnt = 32'd0;
    bus.mis_en    = 1'b0;
    bus.mis_id    = '0;
    bus.halt      = 1'b0;
    bus.rob_ppdst = '0;
    drive(2'b11, 2'b11, 1'b1);
    rst_n = 1'b0;

    // slot fields: ppd1 -> rob_ppdst[1], ppd0 -> rob_ppdst[0]
    vecs[0] = '{2'b11, 2'b11, 1'b1, 7'd5,   7'd9, 2'b11, 2};
    vecs[1] = '{2'b11, 2'b10, 1'b1, 7'd1,   7'd2, 2'b00, 0};
    vecs[2] = '{2'b11, 2'b01, 1'b1, 7'd3,   7'd4, 2'b01, 1};
    vecs[3] = '{2'b11, 2'b11, 1'b0, 7'd6,   7'd7, 2'b00, 0};
    vecs[4] = '{2'b00, 2'b11, 1'b1, 7'd8,   7'd9, 2'b00, 0};
    vecs[5] = '{2'b01, 2'b11, 1'b1, 7'd10,  7'd11, 2'b01, 1};
    vecs[6] = '{2'b10, 2'b11, 1'b1, 7'd12,  7'd13, 2'b00, 0};
    vecs[7] = '{2'b11, 2'b11, 1'b1, 7'd127, 7'd0, 2'b11, 2};

    // Reset state: pops held off even though the head is committable.
    #2;
    chk("reset_pop",    64'(bus.rob_pop),    64'd0);
    chk("reset_push",   64'(bus.fl_push),    64'd0);
    chk("reset_rec_en", 64'(bus.rob_rec_en), 64'd0);
    chk("reset_rec_id", 64'(bus.rob_rec_id), 64'd0);
    chk("reset_stall",  64'(bus.fe_stall),   64'd0);
    chk("reset_cnt",    64'(bus.commit_cnt), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].valid, vecs[i].exec, vecs[i].fl_ready);
      bus.rob_ppdst[1] = vecs[i].ppd1;
      bus.rob_ppdst[0] = vecs[i].ppd0;
      #2;
      chk($sformatf("vec%0d_pop", i),  64'(bus.rob_pop), 64'(vecs[i].exp_pop));
      chk($sformatf("vec%0d_push", i), 64'(bus.fl_push), 64'(vecs[i].exp_pop));
      if (vecs[i].exp_pop[0]) chk($sformatf("vec%0d_data0", i), 64'(bus.fl_data[0]), 64'(vecs[i].ppd0));
      if (vecs[i].exp_pop[1]) chk($sformatf("vec%0d_data1", i), 64'(bus.fl_data[1]), 64'(vecs[i].ppd1));
      chk($sformatf("vec%0d_stall", i), 64'(bus.fe_stall), 64'd0);
      tick();
      exp_cnt = exp_cnt + 32'(vecs[i].exp_delta);
      chk($sformatf("vec%0d_cnt", i), 64'(bus.commit_cnt), 64'(exp_cnt));
    end

    // fl_ready low for several cycles, then released.
    drive(2'b11, 2'b11, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("flr_hold_pop", 64'(bus.rob_pop), 64'd0);
      tick();
    end
    chk("flr_hold_cnt", 64'(bus.commit_cnt), 64'(exp_cnt));
    bus.fl_ready = 1'b1;
    #2;
    chk("flr_release_pop", 64'(bus.rob_pop), 64'b11);
    tick();
    exp_cnt = exp_cnt + 32'd2;
    chk("flr_release_cnt", 64'(bus.commit_cnt), 64'(exp_cnt));

    // Mispredict at id 127: commit still happens in the mis_en cycle, tail wraps to 0.
    drive(2'b11, 2'b01, 1'b1);
    bus.mis_en = 1'b1;
    bus.mis_id = 7'd127;
    #2;
    chk("mis_cycle_pop", 64'(bus.rob_pop), 64'b01);
    tick();
    exp_cnt = exp_cnt + 32'd1;
    bus.mis_id = 7'd5;          // second report inside the window must be ignored
    drive(2'b11, 2'b11, 1'b1);
    #2;
    chk("mis_rec_en",  64'(bus.rob_rec_en), 64'd1);
    chk("mis_rec_id",  64'(bus.rob_rec_id), 64'd0);
    chk("mis_stall1",  64'(bus.fe_stall),   64'd1);
    chk("mis_pop1",    64'(bus.rob_pop),    64'd0);
    tick();
    bus.mis_en = 1'b0;
    #2;
    chk("mis_rec_en_off", 64'(bus.rob_rec_en), 64'd0);
    chk("mis_stall2",     64'(bus.fe_stall),   64'd1);
    chk("mis_pop2",       64'(bus.rob_pop),    64'd0);
    tick();
    #2;
    chk("mis_exit_stall", 64'(bus.fe_stall),   64'd0);
    chk("mis_exit_rec",   64'(bus.rob_rec_en), 64'd0);
    chk("mis_exit_id",    64'(bus.rob_rec_id), 64'd0);
    chk("mis_exit_pop",   64'(bus.rob_pop),    64'b11);
    tick();
    exp_cnt = exp_cnt + 32'd2;
    chk("mis_cnt", 64'(bus.commit_cnt), 64'(exp_cnt));

    // Simultaneous halt + mis_en: recovery first, then HALTED while halt stays high.
    bus.halt   = 1'b1;
    bus.mis_en = 1'b1;
    bus.mis_id = 7'd10;
    #2;
    chk("hm_pop0", 64'(bus.rob_pop), 64'd0);
    tick();
    bus.mis_en = 1'b0;
    #2;
    chk("hm_rec_en", 64'(bus.rob_rec_en), 64'd1);
    chk("hm_rec_id", 64'(bus.rob_rec_id), 64'd11);
    chk("hm_stall1", 64'(bus.fe_stall),   64'd1);
    tick();
    #2;
    chk("hm_stall2", 64'(bus.fe_stall), 64'd1);
    tick();
    for (int c = 0; c < 2; c++) begin
      #2;
      chk("hm_halted_stall", 64'(bus.fe_stall), 64'd0);
      chk("hm_halted_pop",   64'(bus.rob_pop),  64'd0);
      tick();
    end
    bus.halt = 1'b0;
    #2;
    chk("hm_drop_pop", 64'(bus.rob_pop), 64'd0);
    tick();
    #2;
    chk("hm_run_pop", 64'(bus.rob_pop), 64'b11);
    tick();
    exp_cnt = exp_cnt + 32'd2;
    chk("hm_cnt", 64'(bus.commit_cnt), 64'(exp_cnt));

    // Plain halt in RUN: no pops in the halt cycle nor while halted.
    bus.halt = 1'b1;
    #2;
    chk("halt_cycle_pop", 64'(bus.rob_pop), 64'd0);
    tick();
    bus.halt = 1'b0;
    #2;
    chk("halted_pop", 64'(bus.rob_pop), 64'd0);
    tick();
    #2;
    chk("unhalt_pop", 64'(bus.rob_pop), 64'b11);
    tick();
    exp_cnt = exp_cnt + 32'd2;
    chk("halt_cnt", 64'(bus.commit_cnt), 64'(exp_cnt));

    // Reset in the middle of FLUSH.
    drive(2'b00, 2'b00, 1'b1);
    bus.mis_en = 1'b1;
    bus.mis_id = 7'd20;
    tick();
    bus.mis_en = 1'b0;
    drive(2'b11, 2'b11, 1'b1);
    #2;
    chk("rf_rec_en_pre", 64'(bus.rob_rec_en), 64'd1);
    chk("rf_rec_id_pre", 64'(bus.rob_rec_id), 64'd21);
    rst_n = 1'b0;
    #1;
    chk("rf_rec_en", 64'(bus.rob_rec_en), 64'd0);
    chk("rf_rec_id", 64'(bus.rob_rec_id), 64'd0);
    chk("rf_stall",  64'(bus.fe_stall),   64'd0);
    chk("rf_pop",    64'(bus.rob_pop),    64'd0);
    chk("rf_push",   64'(bus.fl_push),    64'd0);
    chk("rf_cnt",    64'(bus.commit_cnt), 64'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    exp_cnt = 32'd0;
    #1;
    chk("rf_after_pop",   64'(bus.rob_pop),  64'b11);
    chk("rf_after_stall", 64'(bus.fe_stall), 64'd0);
    tick();
    exp_cnt = exp_cnt + 32'd2;
    chk("rf_after_cnt", 64'(bus.commit_cnt), 64'(exp_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
